lsu_byte_seq: RTL and testbench

Load/store initiator that sits between the RV32I execute stage and the byte-wide data memory. It accepts one load or store request at a time and sequences it as 1, 2 or 4 single-byte memory accesses, one byte per cycle. For loads it assembles the result and sign- or zero-extends it. It uses the same big-endian byte order as the data memory: the lowest address holds the most significant byte.

---
 rtl/lsu_byte_seq.sv | 151 +++++++++++++++
 tb/tb_lsu_byte_seq.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_byte_seq.sv
// Byte-serial load/store sequencer between the RV32I execute stage and a byte-wide,
// big-endian data memory: 1, 2 or 4 byte accesses per request, one byte per cycle.
module lsu_byte_seq #(
  parameter int unsigned ADDRESS_WIDTH = 10,
  parameter int unsigned DATA_WIDTH    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_store,
  input  logic [2:0]               req_funct3,
  input  logic [31:0]              req_addr,
  input  logic [31:0]              req_wdata,
  output logic                     resp_valid,
  output logic [31:0]              resp_rdata,
  output logic                     resp_err,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic                     mem_we,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  input  logic [DATA_WIDTH-1:0]    mem_rdata
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t                   state_q, state_d;
  logic [1:0]               idx_q;
  logic [XLEN-1:0]          acc_q;
  logic                     store_q;
  logic [2:0]               funct3_q;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [XLEN-1:0]          wdata_q;
  logic                     err_q;

  logic                     accept;
  logic                     illegal;
  logic [1:0]               last_idx;
  logic [1:0]               byte_sel;
  logic [XLEN-1:0]          load_ext;
  logic                     unused_addr_hi;

  // Upper request address bits are outside the memory and deliberately dropped.
  assign unused_addr_hi = ^req_addr[31:ADDRESS_WIDTH];

  assign accept = req_valid & req_ready;

  // Request legality from funct3, direction and natural alignment.
  always_comb begin
    illegal = 1'b1;
    case (req_funct3)
      3'b000:  illegal = 1'b0;
      3'b001:  illegal = req_addr[0];
      3'b010:  illegal = |req_addr[1:0];
      3'b100:  illegal = req_store;
      3'b101:  illegal = req_store | req_addr[0];
      default: illegal = 1'b1;
    endcase
  end

  // Index of the final byte (n-1); store bytes go out MSB first.
  always_comb begin
    case (funct3_q[1:0])
      2'b01:   last_idx = 2'd1;
      2'b10:   last_idx = 2'd3;
      default: last_idx = 2'd0;
    endcase
    byte_sel = last_idx - idx_q;
  end

  always_comb begin
    case (funct3_q)
      3'b000:  load_ext = {{24{acc_q[7]}}, acc_q[7:0]};
      3'b100:  load_ext = {24'b0, acc_q[7:0]};
      3'b001:  load_ext = {{16{acc_q[15]}}, acc_q[15:0]};
      3'b101:  load_ext = {16'b0, acc_q[15:0]};
      default: load_ext = acc_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state and Moore outputs; reset forces every output low.
  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    resp_rdata = '0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = illegal ? DONE : ACCESS;
      end
      ACCESS: begin
        mem_addr = addr_q + ADDRESS_WIDTH'(idx_q);
        mem_we   = store_q;
        if (store_q) mem_wdata = wdata_q[{byte_sel, 3'b000} +: DATA_WIDTH];
        if (idx_q == last_idx) state_d = DONE;
      end
      DONE: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        resp_rdata = (err_q || store_q) ? '0 : load_ext;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (rst) begin
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      resp_err   = 1'b0;
      resp_rdata = '0;
      mem_we     = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
    end
  end

  // Request capture and byte accumulation; acc clears on accept so narrow loads start clean.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q    <= '0;
      acc_q    <= '0;
      store_q  <= 1'b0;
      funct3_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      err_q    <= 1'b0;
    end else if (accept) begin
      idx_q    <= '0;
      acc_q    <= '0;
      store_q  <= req_store;
      funct3_q <= req_funct3;
      addr_q   <= req_addr[ADDRESS_WIDTH-1:0];
      wdata_q  <= req_wdata;
      err_q    <= illegal;
    end else if (state_q == ACCESS) begin
      idx_q <= idx_q + 2'd1;
      if (!store_q) acc_q <= {acc_q[XLEN-DATA_WIDTH-1:0], mem_rdata};
    end
  end

endmodule

// File: tb/tb_lsu_byte_seq.sv
// Bench for lsu_byte_seq: directed test-plan cases with literal expectations, then
// randomized traffic with random resets, all checked each cycle against a transaction model.
module tb_lsu_byte_seq;

  localparam int unsigned AW    = 10;
  localparam int unsigned MSIZE = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_store;
  logic [2:0]    req_funct3;
  logic [31:0]   req_addr;
  logic [31:0]   req_wdata;
  logic          resp_valid;
  logic [31:0]   resp_rdata;
  logic          resp_err;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [7:0]    mem_wdata;
  logic [7:0]    mem_rdata;

  logic [7:0] env_mem [0:MSIZE-1];
  logic [7:0] ref_mem [0:MSIZE-1];

  int checks   = 0;
  int failures = 0;
  int cycle    = 0;

  lsu_byte_seq #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Byte-wide memory environment: combinational read, write on the clock edge.
  assign mem_rdata = env_mem[mem_addr];
  always @(posedge clk) begin
    cycle <= cycle + 1;
    if (mem_we) env_mem[mem_addr] <= mem_wdata;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", name, cycle, act, exp);
    end
  endtask

  // Transaction model: a request accepted in cycle T owns cycles T+1..T+n for byte
  // accesses and answers in the cycle after; an illegal one answers at T+1.
  initial begin : model
    int          step;
    int          n;
    bit          m_err, m_store;
    logic [31:0] m_addr, m_wdata, m_res;
    logic [31:0] e_ready, e_rv, e_err, e_rd, e_we, e_ma, e_wd;
    step = 0; n = 0; m_err = 0; m_store = 0; m_addr = 0; m_wdata = 0; m_res = 0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      e_ready = 0; e_rv = 0; e_err = 0; e_rd = 0; e_we = 0; e_ma = 0; e_wd = 0;
      if (rst) begin
        step = 0;
      end else if (step == 0) begin
        e_ready = 1;
        if (req_valid) begin
          m_store = req_store;
          m_addr  = req_addr;
          m_wdata = req_wdata;
          case (req_funct3)
            3'd0, 3'd4: n = 1;
            3'd1, 3'd5: n = 2;
            3'd2:       n = 4;
            default:    n = 0;
          endcase
          m_err = (n == 0) || (m_store && req_funct3[2]) || ((m_addr % n) != 0);
          m_res = 0;
          if (!m_err && !m_store) begin
            for (int i = 0; i < n; i++)
              m_res = m_res * 256 + 32'(ref_mem[(m_addr + i) % MSIZE]);
            if (!req_funct3[2] && n < 4 && m_res >= (32'd1 << (8 * n - 1)))
              m_res = m_res | ~((32'd1 << (8 * n)) - 1);
          end
          step = 1;
        end
      end else if (!m_err && step <= n) begin
        e_ma = (m_addr + step - 1) % MSIZE;
        if (m_store) begin
          e_we = 1;
          e_wd = (m_wdata >> (8 * (n - step))) & 32'hFF;
          ref_mem[e_ma] = e_wd[7:0];
        end
        step++;
      end else begin
        e_rv  = 1;
        e_err = 32'(m_err);
        e_rd  = m_res;
        step  = 0;
      end
      chk("req_ready",  32'(req_ready),  e_ready);
      chk("resp_valid", 32'(resp_valid), e_rv);
      chk("resp_err",   32'(resp_err),   e_err);
      chk("resp_rdata", resp_rdata,      e_rd);
      chk("mem_we",     32'(mem_we),     e_we);
      chk("mem_addr",   32'(mem_addr),   e_ma);
      chk("mem_wdata",  32'(mem_wdata),  e_wd);
    end
  end

  // Directed request from IDLE; waits (bounded) for the response and checks latency and data.
  task automatic do_req(input string name, input logic st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_err, input int exp_lat);
    int lat;
    bit got;
    @(posedge clk); #1;
    req_valid = 1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
    lat = 0; got = 0;
    while (lat < 20 && !got) begin
      @(negedge clk);
      if (resp_valid) got = 1;
      else begin
        @(posedge clk); #1;
        req_valid = 0;
        lat++;
      end
    end
    chk({name, "_got_resp"}, 32'(got), 1);
    chk({name, "_latency"},  32'(lat), 32'(exp_lat));
    chk({name, "_rdata"},    resp_rdata, exp_rd);
    chk({name, "_err"},      32'(resp_err), 32'(exp_err));
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog cycle=%0d got=timeout expected=finish", cycle);
    $fatal(1, "timeout");
  end

  initial begin : stim
    bit acc;
    int f3;
    rst = 1; req_valid = 0; req_store = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0;
    for (int i = 0; i < MSIZE; i++) begin
      env_mem[i] = 8'($urandom);
      ref_mem[i] = env_mem[i];
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ready",  32'(req_ready), 0);
    chk("reset_resp",   32'(resp_valid), 0);
    chk("reset_mem_we", 32'(mem_we), 0);
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("ready_after_reset", 32'(req_ready), 1);

    do_req("sw_10",   1, 3'd2, 32'h10, 32'h11223344, 32'h0, 0, 5);
    do_req("lw_10",   0, 3'd2, 32'h10, 32'h0, 32'h11223344, 0, 5);
    do_req("lw_hi",   0, 3'd2, 32'h0000_0410, 32'h0, 32'h11223344, 0, 5);
    do_req("sb_20",   1, 3'd0, 32'h20, 32'hDEADBE80, 32'h0, 0, 2);
    do_req("lb_20",   0, 3'd0, 32'h20, 32'h0, 32'hFFFFFF80, 0, 2);
    do_req("lbu_20",  0, 3'd4, 32'h20, 32'h0, 32'h00000080, 0, 2);
    do_req("sh_30",   1, 3'd1, 32'h30, 32'h1234F00D, 32'h0, 0, 3);
    do_req("lh_30",   0, 3'd1, 32'h30, 32'h0, 32'hFFFFF00D, 0, 3);
    do_req("lhu_30",  0, 3'd5, 32'h30, 32'h0, 32'h0000F00D, 0, 3);
    do_req("lw_mis",  0, 3'd2, 32'h12, 32'h0, 32'h0, 1, 1);
    do_req("sh_mis",  1, 3'd1, 32'h31, 32'hFFFF, 32'h0, 1, 1);
    do_req("sbu_ill", 1, 3'd4, 32'h20, 32'hFF, 32'h0, 1, 1);
    do_req("f3_011",  0, 3'd3, 32'h20, 32'h0, 32'h0, 1, 1);
    do_req("sw_3fc",  1, 3'd2, 32'h3FC, 32'hAABBCCDD, 32'h0, 0, 5);
    do_req("lh_3fe",  0, 3'd1, 32'h3FE, 32'h0, 32'hFFFFCCDD, 0, 3);
    do_req("lw_3fc",  0, 3'd2, 32'h3FC, 32'h0, 32'hAABBCCDD, 0, 5);

    // Reset in the third access cycle of a word store.
    @(posedge clk); #1;
    for (int i = 'h40; i < 'h44; i++) begin
      env_mem[i] = 8'h00;
      ref_mem[i] = 8'h00;
    end
    req_valid = 1; req_store = 1; req_funct3 = 3'd2; req_addr = 32'h40; req_wdata = 32'h55667788;
    @(posedge clk); #1 req_valid = 0;
    @(posedge clk);
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("abort_ready", 32'(req_ready), 1);
    chk("abort_m40", 32'(env_mem['h40]), 32'h55);
    chk("abort_m41", 32'(env_mem['h41]), 32'h66);
    chk("abort_m42", 32'(env_mem['h42]), 32'h00);
    chk("abort_m43", 32'(env_mem['h43]), 32'h00);

    // Random traffic: requests held until accepted, occasional resets.
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      acc = req_valid && req_ready;
      @(posedge clk); #1;
      if (acc) req_valid = 0;
      if (!req_valid && $urandom_range(0, 1) == 1) begin
        if ($urandom_range(0, 7) == 0) f3 = $urandom_range(0, 7);
        else case ($urandom_range(0, 4))
          0: f3 = 0; 1: f3 = 1; 2: f3 = 2; 3: f3 = 4; default: f3 = 5;
        endcase
        req_valid  = 1;
        req_store  = 1'($urandom_range(0, 1));
        req_funct3 = 3'(f3);
        req_addr   = $urandom;
        if ($urandom_range(0, 3) != 0) req_addr = req_addr & ~32'h3;
        req_wdata  = $urandom;
      end
      rst = ($urandom_range(0, 99) == 0);
    end
    @(posedge clk); #1 rst = 0; req_valid = 0;
    repeat (8) @(posedge clk);
    for (int i = 0; i < MSIZE; i++) chk("final_mem", 32'(env_mem[i]), 32'(ref_mem[i]));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
